// File: rtl/csr_irq_ctrl.sv
// Machine-mode CSR file with trap/interrupt arbitration, WARL mtvec, counters
// with mcountinhibit, and a WFI sleep state that stalls the pipeline.
module csr_irq_ctrl #(
    parameter int unsigned NUM_LOCAL = 4,
    parameter logic [31:0] MISA_VAL  = 32'h40001104,
    parameter int unsigned CNT_W     = 64
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       rden,
    input  logic [11:0]                                raddr,
    output logic [31:0]                                rdata,
    input  logic                                       wren,
    input  logic [11:0]                                waddr,
    input  logic [31:0]                                wdata,
    input  logic                                       valid,
    input  logic                                       exc,
    input  logic [4:0]                                 ecause,
    input  logic [31:0]                                epc,
    input  logic [31:0]                                etval,
    input  logic                                       mret,
    input  logic                                       wfi,
    input  logic                                       meip,
    input  logic                                       mtip,
    input  logic                                       msip,
    input  logic [((NUM_LOCAL > 0) ? NUM_LOCAL : 1)-1:0] lip,
    output logic                                       trap,
    output logic [31:0]                                trap_vec,
    output logic                                       mret_out,
    output logic [31:0]                                mepc_out,
    output logic                                       stall
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MCINH     = 12'h320;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;

    localparam logic [15:0] LOC_MASK = 16'hFFFF >> (16 - NUM_LOCAL);
    localparam logic [31:0] MIE_MASK = {LOC_MASK, 16'h0888};

    typedef enum logic {RUN, SLEEP} state_t;

    state_t           state;
    logic             st_mie, st_mpie;
    logic [31:0]      mie_q, mip_q, mtvec_q, mcinh_q, mscratch_q;
    logic [31:0]      mepc_q, mcause_q, mtval_q, wake_pc;
    logic [CNT_W-1:0] mcycle_q, minstret_q;
    logic             trap_q, mret_q;
    logic [31:0]      trap_vec_q;

    logic [15:0] lip_ext;
    logic [31:0] pend, base, trap_tgt, trap_pc;
    logic [4:0]  irq_cause;
    logic        irq_any, in_run, take_exc, take_irq, take_trap, take_mret, go_sleep;

    assign lip_ext = 16'(lip) & LOC_MASK;
    assign pend    = mip_q & mie_q;
    assign irq_any = |pend;

    // Later assignments override earlier ones, so the order below is lowest
    // priority first: local lines ascending, then MTI, MSI, MEI.
    always_comb begin
        irq_cause = 5'd0;
        for (int i = 16; i < 32; i++)
            if (pend[i]) irq_cause = 5'(i);
        if (pend[7])  irq_cause = 5'd7;
        if (pend[3])  irq_cause = 5'd3;
        if (pend[11]) irq_cause = 5'd11;
    end

    assign in_run    = (state == RUN);
    assign take_exc  = in_run && exc;
    assign take_irq  = !take_exc && st_mie && irq_any && (!in_run || valid);
    assign take_trap = take_exc || take_irq;
    assign take_mret = in_run && mret && !take_trap;
    assign go_sleep  = in_run && valid && wfi && !take_trap;

    assign base     = {mtvec_q[31:2], 2'b00};
    assign trap_tgt = (take_irq && mtvec_q[1:0] == 2'b01) ? base + {25'b0, irq_cause, 2'b00} : base;
    assign trap_pc  = in_run ? epc : wake_pc;

    assign trap     = trap_q;
    assign trap_vec = trap_vec_q;
    assign mret_out = mret_q;
    assign mepc_out = mepc_q;
    // Stall releases in the same cycle the wake condition appears.
    assign stall    = !in_run && !irq_any;

    always_comb begin
        rdata = 32'h0;
        if (rden) begin
            case (raddr)
                A_MSTATUS:   rdata = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
                A_MISA:      rdata = MISA_VAL;
                A_MIE:       rdata = mie_q;
                A_MTVEC:     rdata = mtvec_q;
                A_MCINH:     rdata = mcinh_q;
                A_MSCRATCH:  rdata = mscratch_q;
                A_MEPC:      rdata = mepc_q;
                A_MCAUSE:    rdata = mcause_q;
                A_MTVAL:     rdata = mtval_q;
                A_MIP:       rdata = mip_q;
                A_MCYCLE:    rdata = mcycle_q[31:0];
                A_MCYCLEH:   rdata = 32'(mcycle_q[CNT_W-1:32]);
                A_MINSTRET:  rdata = minstret_q[31:0];
                A_MINSTRETH: rdata = 32'(minstret_q[CNT_W-1:32]);
                default:     rdata = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= RUN;
            st_mie     <= 1'b0;
            st_mpie    <= 1'b0;
            mie_q      <= '0;
            mip_q      <= '0;
            mtvec_q    <= '0;
            mcinh_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            wake_pc    <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
            trap_q     <= 1'b0;
            mret_q     <= 1'b0;
            trap_vec_q <= '0;
        end else begin
            mip_q  <= {lip_ext, 4'b0, meip, 3'b0, mtip, 3'b0, msip, 3'b0};
            trap_q <= take_trap;
            mret_q <= take_mret;

            if (wren && waddr == A_MIE)      mie_q      <= wdata & MIE_MASK;
            if (wren && waddr == A_MTVEC)    mtvec_q    <= {wdata[31:2], wdata[1] ? 2'b00 : wdata[1:0]};
            if (wren && waddr == A_MCINH)    mcinh_q    <= wdata & 32'h5;
            if (wren && waddr == A_MSCRATCH) mscratch_q <= wdata;

            // Trap entry owns mstatus/mepc/mcause/mtval; a racing CSR write is dropped.
            if (take_trap) begin
                st_mpie    <= st_mie;
                st_mie     <= 1'b0;
                mepc_q     <= {trap_pc[31:2], 2'b00};
                mcause_q   <= take_exc ? {27'b0, ecause} : {1'b1, 26'b0, irq_cause};
                mtval_q    <= take_exc ? etval : 32'h0;
                trap_vec_q <= trap_tgt;
            end else begin
                if (take_mret) begin
                    st_mie  <= st_mpie;
                    st_mpie <= 1'b1;
                end else if (wren && waddr == A_MSTATUS) begin
                    st_mie  <= wdata[3];
                    st_mpie <= wdata[7];
                end
                if (wren && waddr == A_MEPC)   mepc_q   <= {wdata[31:2], 2'b00};
                if (wren && waddr == A_MCAUSE) mcause_q <= wdata & 32'h8000001F;
                if (wren && waddr == A_MTVAL)  mtval_q  <= wdata;
            end

            if (wren && waddr == A_MCYCLE)       mcycle_q[31:0]       <= wdata;
            else if (wren && waddr == A_MCYCLEH) mcycle_q[CNT_W-1:32] <= wdata[CNT_W-33:0];
            else if (!mcinh_q[0])                mcycle_q             <= mcycle_q + CNT_W'(1);

            if (wren && waddr == A_MINSTRET)       minstret_q[31:0]       <= wdata;
            else if (wren && waddr == A_MINSTRETH) minstret_q[CNT_W-1:32] <= wdata[CNT_W-33:0];
            else if (in_run && valid && !mcinh_q[2]) minstret_q           <= minstret_q + CNT_W'(1);

            case (state)
                RUN: if (go_sleep) begin
                    state   <= SLEEP;
                    wake_pc <= epc + 32'd4;
                end
                SLEEP: if (irq_any) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_irq_ctrl.sv
// Self-checking bench for csr_irq_ctrl: WARL table, directed trap/WFI/counter
// sequences, then randomized traffic against an architectural reference model.
module tb_csr_irq_ctrl;
    localparam int NL = 4;

    logic        clk = 1'b0, rst = 1'b0;
    logic        rden = 1'b0, wren = 1'b0;
    logic [11:0] raddr = '0, waddr = '0;
    logic [31:0] rdata, wdata = '0, epc = '0, etval = '0;
    logic        valid = 1'b0, exc = 1'b0, mret = 1'b0, wfi = 1'b0;
    logic [4:0]  ecause = '0;
    logic        meip = 1'b0, mtip = 1'b0, msip = 1'b0;
    logic [NL-1:0] lip = '0;
    logic        trap, mret_out, stall;
    logic [31:0] trap_vec, mepc_out;

    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    csr_irq_ctrl #(.NUM_LOCAL(NL), .MISA_VAL(32'h40001104), .CNT_W(64)) dut (
        .clk(clk), .rst(rst), .rden(rden), .raddr(raddr), .rdata(rdata),
        .wren(wren), .waddr(waddr), .wdata(wdata), .valid(valid), .exc(exc),
        .ecause(ecause), .epc(epc), .etval(etval), .mret(mret), .wfi(wfi),
        .meip(meip), .mtip(mtip), .msip(msip), .lip(lip), .trap(trap),
        .trap_vec(trap_vec), .mret_out(mret_out), .mepc_out(mepc_out), .stall(stall)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        wren = 1'b1; waddr = a; wdata = d;
        tick();
        wren = 1'b0;
    endtask

    task automatic csr_rd(input logic [11:0] a, output logic [31:0] d);
        rden = 1'b1; raddr = a;
        #1;
        d = rdata;
        rden = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] v;
        csr_rd(a, v);
        chk(name, v, exp);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
    endtask

    // ---------------- reference model ----------------
    logic        m_mie, m_mpie, m_sleep, m_trap, m_mret;
    logic [31:0] m_ie, m_ip, m_tvec, m_cinh, m_scr, m_epc, m_cause, m_tval, m_wpc, m_tvo;
    logic [63:0] m_cyc, m_ret;
    int          prio[$];

    task automatic m_reset();
        {m_mie, m_mpie, m_sleep, m_trap, m_mret} = '0;
        {m_ie, m_ip, m_tvec, m_cinh, m_scr, m_epc, m_cause, m_tval, m_wpc, m_tvo} = '0;
        m_cyc = '0; m_ret = '0;
    endtask

    function automatic logic [31:0] m_read(input logic en, input logic [11:0] a);
        if (!en) return 32'h0;
        case (a)
            12'h300: return 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
            12'h301: return 32'h40001104;
            12'h304: return m_ie;
            12'h305: return m_tvec;
            12'h320: return m_cinh;
            12'h340: return m_scr;
            12'h341: return m_epc;
            12'h342: return m_cause;
            12'h343: return m_tval;
            12'h344: return m_ip;
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            12'hB02: return m_ret[31:0];
            12'hB82: return m_ret[63:32];
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_step();
        logic [31:0] pend, nip, base;
        logic any, found, dexc, dirq, dtrap, dmret, dsleep, old_mie;
        int   cz;
        pend = m_ip & m_ie;
        any  = (pend != 0);
        cz = 0; found = 1'b0;
        for (int k = 0; k < prio.size(); k++)
            if (!found && pend[prio[k]]) begin cz = prio[k]; found = 1'b1; end
        dexc   = !m_sleep && exc;
        dirq   = !dexc && m_mie && any && (m_sleep || valid);
        dtrap  = dexc || dirq;
        dmret  = !m_sleep && mret && !dtrap;
        dsleep = !m_sleep && valid && wfi && !dtrap;
        base   = m_tvec & ~32'h3;
        nip = '0;
        nip[3] = msip; nip[7] = mtip; nip[11] = meip;
        for (int k = 0; k < NL; k++) nip[16+k] = lip[k];

        if (wren && waddr == 12'hB00)      m_cyc[31:0]  = wdata;
        else if (wren && waddr == 12'hB80) m_cyc[63:32] = wdata;
        else if (!m_cinh[0])               m_cyc        = m_cyc + 64'd1;
        if (wren && waddr == 12'hB02)      m_ret[31:0]  = wdata;
        else if (wren && waddr == 12'hB82) m_ret[63:32] = wdata;
        else if (!m_sleep && valid && !m_cinh[2]) m_ret = m_ret + 64'd1;

        m_trap = dtrap;
        m_mret = dmret;
        if (dtrap) begin
            m_tvo   = (dirq && m_tvec[1:0] == 2'b01) ? base + 32'(cz) * 4 : base;
            m_epc   = (m_sleep ? m_wpc : epc) & ~32'h3;
            m_cause = dexc ? 32'(ecause) : (32'h80000000 | 32'(cz));
            m_tval  = dexc ? etval : 32'h0;
            m_mpie  = m_mie;
            m_mie   = 1'b0;
        end else begin
            if (dmret) begin
                old_mie = m_mpie;
                m_mie = old_mie; m_mpie = 1'b1;
            end else if (wren && waddr == 12'h300) begin
                m_mie = wdata[3]; m_mpie = wdata[7];
            end
            if (wren && waddr == 12'h341) m_epc   = wdata & ~32'h3;
            if (wren && waddr == 12'h342) m_cause = wdata & 32'h8000001F;
            if (wren && waddr == 12'h343) m_tval  = wdata;
        end
        if (wren && waddr == 12'h304) m_ie   = wdata & 32'h000F0888;
        if (wren && waddr == 12'h305) m_tvec = (wdata[1:0] >= 2) ? wdata & ~32'h3 : wdata;
        if (wren && waddr == 12'h320) m_cinh = wdata & 32'h5;
        if (wren && waddr == 12'h340) m_scr  = wdata;

        if (dsleep) begin m_sleep = 1'b1; m_wpc = epc + 32'd4; end
        else if (m_sleep && any) m_sleep = 1'b0;
        m_ip = nip;
    endtask

    typedef struct { logic [11:0] a; logic [31:0] d; logic [31:0] exp; } vec_t;
    vec_t tbl [13];

    logic [11:0] waddrs [14] = '{12'h300, 12'h304, 12'h305, 12'h320, 12'h340, 12'h341, 12'h342,
                                 12'h343, 12'h344, 12'h301, 12'hB00, 12'hB80, 12'hB02, 12'hB82};
    logic [11:0] raddrs [15] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h320, 12'h340, 12'h341,
                                 12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h7C0};

    initial begin
        prio = {11, 3, 7};
        for (int k = 31; k >= 16; k--) prio.push_back(k);

        tbl[0]  = '{12'h304, 32'hFFFFFFFF, 32'h000F0888};
        tbl[1]  = '{12'h341, 32'hFFFFFFFF, 32'hFFFFFFFC};
        tbl[2]  = '{12'h342, 32'hFFFFFFFF, 32'h8000001F};
        tbl[3]  = '{12'h305, 32'h00001002, 32'h00001000};
        tbl[4]  = '{12'h305, 32'h00001003, 32'h00001000};
        tbl[5]  = '{12'h305, 32'h00001001, 32'h00001001};
        tbl[6]  = '{12'h320, 32'hFFFFFFFF, 32'h00000005};
        tbl[7]  = '{12'h340, 32'h12345678, 32'h12345678};
        tbl[8]  = '{12'h300, 32'hFFFFFFFF, 32'h00001888};
        tbl[9]  = '{12'h344, 32'hFFFFFFFF, 32'h00000000};
        tbl[10] = '{12'h301, 32'h00000000, 32'h40001104};
        tbl[11] = '{12'h343, 32'h0000DEAD, 32'h0000DEAD};
        tbl[12] = '{12'h7C0, 32'hFFFFFFFF, 32'h00000000};

        // reset state
        do_reset();
        rd_chk("rst_misa", 12'h301, 32'h40001104);
        rd_chk("rst_mtvec", 12'h305, 32'h0);
        rd_chk("rst_mepc", 12'h341, 32'h0);
        rd_chk("rst_mip", 12'h344, 32'h0);
        rd_chk("rst_unmapped", 12'h7C0, 32'h0);
        rd_chk("rst_mstatus", 12'h300, 32'h1800);
        raddr = 12'h301; #1;
        chk("rden_low", rdata, 32'h0);
        chk("rst_trap", {31'b0, trap}, 32'h0);
        chk("rst_mret_out", {31'b0, mret_out}, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_trap_vec", trap_vec, 32'h0);

        // WARL write/read table
        for (int i = 0; i < 13; i++) begin
            csr_wr(tbl[i].a, tbl[i].d);
            rd_chk($sformatf("warl[%0d]", i), tbl[i].a, tbl[i].exp);
        end

        // vectored MEI trap, then mret
        do_reset();
        csr_wr(12'h305, 32'h1001);
        csr_wr(12'h304, 32'h800);
        csr_wr(12'h300, 32'h8);
        meip = 1'b1; tick();
        valid = 1'b1; epc = 32'h200; tick(); valid = 1'b0;
        chk("mei_trap", {31'b0, trap}, 32'h1);
        chk("mei_vec", trap_vec, 32'h102C);
        rd_chk("mei_mcause", 12'h342, 32'h8000000B);
        rd_chk("mei_mepc", 12'h341, 32'h200);
        rd_chk("mei_mstatus", 12'h300, 32'h1880);
        tick();
        chk("trap_pulse", {31'b0, trap}, 32'h0);
        mret = 1'b1; tick(); mret = 1'b0;
        chk("mret_out", {31'b0, mret_out}, 32'h1);
        chk("mret_mepc_out", mepc_out, 32'h200);
        rd_chk("mret_mstatus", 12'h300, 32'h1888);

        // exception beats pending MEI and a coincident mret
        exc = 1'b1; ecause = 5'd2; etval = 32'hBAD; valid = 1'b1; mret = 1'b1; epc = 32'h400;
        tick();
        {exc, valid, mret} = '0;
        chk("exc_trap", {31'b0, trap}, 32'h1);
        chk("exc_no_mret", {31'b0, mret_out}, 32'h0);
        chk("exc_vec", trap_vec, 32'h1000);
        rd_chk("exc_mcause", 12'h342, 32'h2);
        rd_chk("exc_mtval", 12'h343, 32'hBAD);
        rd_chk("exc_mepc", 12'h341, 32'h400);
        meip = 1'b0;

        // local-line priority, then MSI over local
        csr_wr(12'h304, 32'h000F0008);
        lip = 4'b1010;
        csr_wr(12'h300, 32'h8);
        valid = 1'b1; tick(); valid = 1'b0;
        rd_chk("lip_mcause", 12'h342, 32'h80000013);
        chk("lip_vec", trap_vec, 32'h104C);
        msip = 1'b1;
        csr_wr(12'h300, 32'h8);
        valid = 1'b1; tick(); valid = 1'b0;
        rd_chk("msi_mcause", 12'h342, 32'h80000003);
        chk("msi_vec", trap_vec, 32'h100C);
        lip = '0; msip = 1'b0;

        // counters
        csr_wr(12'hB80, 32'h0);
        csr_wr(12'hB00, 32'hFFFFFFFF);
        rd_chk("mcycle_wr", 12'hB00, 32'hFFFFFFFF);
        rd_chk("mcycleh_hold", 12'hB80, 32'h0);
        tick();
        rd_chk("mcycleh_carry", 12'hB80, 32'h1);
        csr_wr(12'h320, 32'h1);
        csr_wr(12'hB00, 32'h55);
        tick(); tick(); tick();
        rd_chk("mcycle_inhibit", 12'hB00, 32'h55);
        csr_wr(12'h320, 32'h0);
        valid = 1'b1; wren = 1'b1; waddr = 12'hB02; wdata = 32'h777;
        tick();
        wren = 1'b0; valid = 1'b0;
        rd_chk("minstret_wr_wins", 12'hB02, 32'h777);
        valid = 1'b1; tick(); tick(); tick(); valid = 1'b0;
        rd_chk("minstret_inc", 12'hB02, 32'h77A);
        csr_wr(12'h320, 32'h4);
        valid = 1'b1; tick(); tick(); valid = 1'b0;
        rd_chk("minstret_inhibit", 12'hB02, 32'h77A);

        // WFI with MIE=0: wake without trap
        do_reset();
        csr_wr(12'h304, 32'h80);
        valid = 1'b1; wfi = 1'b1; epc = 32'h300; tick(); valid = 1'b0; wfi = 1'b0;
        chk("wfi_stall", {31'b0, stall}, 32'h1);
        tick(); tick();
        chk("wfi_stall_hold", {31'b0, stall}, 32'h1);
        mtip = 1'b1; tick();
        chk("wake_stall", {31'b0, stall}, 32'h0);
        tick();
        chk("wake_no_trap", {31'b0, trap}, 32'h0);
        chk("wake_run", {31'b0, stall}, 32'h0);
        mtip = 1'b0; tick();

        // WFI with MIE=1: wake traps with latched pc
        csr_wr(12'h300, 32'h8);
        valid = 1'b1; wfi = 1'b1; epc = 32'h300; tick(); valid = 1'b0; wfi = 1'b0;
        chk("wfi2_stall", {31'b0, stall}, 32'h1);
        mtip = 1'b1; tick();
        chk("wake2_stall", {31'b0, stall}, 32'h0);
        tick();
        chk("wake2_trap", {31'b0, trap}, 32'h1);
        chk("wake2_vec", trap_vec, 32'h0);
        rd_chk("wake2_mepc", 12'h341, 32'h304);
        rd_chk("wake2_mcause", 12'h342, 32'h80000007);
        mtip = 1'b0; tick(); tick();

        // reset while stalled
        valid = 1'b1; wfi = 1'b1; tick(); valid = 1'b0; wfi = 1'b0;
        chk("pre_rst_stall", {31'b0, stall}, 32'h1);
        rst = 1'b0; tick();
        chk("rst_clears_stall", {31'b0, stall}, 32'h0);
        rst = 1'b1; tick();
        chk("post_rst_stall", {31'b0, stall}, 32'h0);

        // randomized traffic against the reference model
        do_reset();
        m_reset();
        for (int c = 0; c < 3000 && (n_chk - n_pass) < 20; c++) begin
            wren   = ($urandom_range(0, 9) < 3);
            waddr  = waddrs[$urandom_range(0, 13)];
            wdata  = $urandom;
            rden   = ($urandom_range(0, 9) != 0);
            raddr  = raddrs[$urandom_range(0, 14)];
            valid  = $urandom_range(0, 1) == 1;
            exc    = ($urandom_range(0, 9) == 0);
            ecause = 5'($urandom_range(0, 31));
            epc    = $urandom;
            etval  = $urandom;
            wfi    = ($urandom_range(0, 9) == 0);
            mret   = ($urandom_range(0, 9) == 0);
            if (mret) begin
                valid = 1'b0;
                if (waddr == 12'h300) wren = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) meip = ~meip;
            if ($urandom_range(0, 7) == 0) mtip = ~mtip;
            if ($urandom_range(0, 7) == 0) msip = ~msip;
            if ($urandom_range(0, 7) == 0) lip  = 4'($urandom);
            #1;
            chk("rnd_rdata", rdata, m_read(rden, raddr));
            chk("rnd_stall", {31'b0, stall}, {31'b0, m_sleep && ((m_ip & m_ie) == 0)});
            chk("rnd_trap", {31'b0, trap}, {31'b0, m_trap});
            chk("rnd_trap_vec", trap_vec, m_tvo);
            chk("rnd_mret_out", {31'b0, mret_out}, {31'b0, m_mret});
            chk("rnd_mepc_out", mepc_out, m_epc);
            m_step();
            tick();
        end
        {wren, rden, valid, exc, wfi, mret} = '0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
